// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencer.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Single-digit BCD to Excess-3 converter with out-of-range detection.
module bcd_xs3_digit
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] xs3,
   output logic       invalid
);

   // 4-bit add wraps naturally, so invalid digits still map to (d+3) mod 16
   assign xs3     = d + XS3_OFFSET;
   assign invalid = (d > BCD_MAX);

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Word-level sequencer: converts packed BCD to Excess-3 one digit per clock,
// LSD first, through a single shared digit converter.
module bcd_xs3_seq_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_xs3,
   output logic [DIGITS-1:0]     out_err,
   output logic                  busy
);

   localparam int unsigned W    = 4 * DIGITS;
   localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [W-1:0]      cap_q, cap_d;
   logic [W-1:0]      xs3_q, xs3_d;
   logic [DIGITS-1:0] err_q, err_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   logic [3:0]        digit_c;
   logic [3:0]        conv_xs3_c;
   logic              conv_inv_c;

   assign digit_c = cap_q[{idx_q, 2'b00} +: 4];

   bcd_xs3_digit u_digit (
      .d       (digit_c),
      .xs3     (conv_xs3_c),
      .invalid (conv_inv_c)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cap_q       <= '0;
         xs3_q       <= '0;
         err_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cap_q       <= cap_d;
         xs3_q       <= xs3_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output logic; flush outranks both handshakes
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cap_d   = cap_q;
      xs3_d   = xs3_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q && !flush) begin
               cap_d   = in_bcd;
               xs3_d   = '0;
               err_d   = '0;
               idx_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            if (flush) begin
               idx_d   = '0;
               err_d   = '0;
               state_d = IDLE;
            end else begin
               xs3_d[{idx_q, 2'b00} +: 4] = conv_xs3_c;
               err_d[idx_q]               = conv_inv_c;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         DONE: begin
            if (flush) begin
               idx_d   = '0;
               err_d   = '0;
               state_d = IDLE;
            end else if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_xs3   = xs3_q;
   assign out_err   = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Directed, table-driven bench for bcd_xs3_seq_ctrl with DIGITS=4.
module tb_bcd_xs3_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bcd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_xs3;
   logic [3:0]  out_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   bcd_xs3_seq_ctrl #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_xs3   (out_xs3),
      .out_err   (out_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic [15:0] xs3;
      logic [3:0]  err;
   } vec_t;

   vec_t vecs[6];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick;
         n++;
      end
      chk({tag, " wait_ready"}, 32'(in_ready), 32'd1);
   endtask

   // Accept one word, check latency, result, and return to IDLE
   task automatic run_word(input logic [15:0] bcd, input logic [15:0] exp_x,
                           input logic [3:0] exp_e, input string tag);
      wait_ready(tag);
      in_valid = 1'b1;
      in_bcd   = bcd;
      tick;
      in_valid = 1'b0;
      in_bcd   = '0;
      chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      chk({tag, " in_ready_after_accept"}, 32'(in_ready), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick;
         chk($sformatf("%s out_valid@T+%0d", tag, i), 32'(out_valid), 32'(i == 4));
      end
      chk({tag, " out_xs3"}, 32'(out_xs3), 32'(exp_x));
      chk({tag, " out_err"}, 32'(out_err), 32'(exp_e));
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
      chk({tag, " busy_drop"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        stable;
      logic        never_valid;
      logic        acc;
      int          nacc;
      int          nres;
      int          acc_cyc[2];
      logic [15:0] exp_res[2];

      vecs[0] = '{bcd: 16'h1234, xs3: 16'h4567, err: 4'b0000};
      vecs[1] = '{bcd: 16'h9090, xs3: 16'hC3C3, err: 4'b0000};
      vecs[2] = '{bcd: 16'h0A0F, xs3: 16'h3D32, err: 4'b0101};
      vecs[3] = '{bcd: 16'h0000, xs3: 16'h3333, err: 4'b0000};
      vecs[4] = '{bcd: 16'hFFFF, xs3: 16'h2222, err: 4'b1111};
      vecs[5] = '{bcd: 16'hB807, xs3: 16'hEB3A, err: 4'b1000};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_bcd    = '0;
      out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst out_xs3", 32'(out_xs3), 32'd0);
      chk("rst out_err", 32'(out_err), 32'd0);
      #15;
      rst_n = 1'b1;
      #1;
      chk("post_release in_ready", 32'(in_ready), 32'd0);
      tick;
      chk("first_edge in_ready", 32'(in_ready), 32'd1);

      for (int v = 0; v < 6; v++)
         run_word(vecs[v].bcd, vecs[v].xs3, vecs[v].err, $sformatf("vec%0d", v));

      // Backpressure with a pending input held high
      wait_ready("bp");
      in_valid = 1'b1;
      in_bcd   = 16'h4321;
      tick;
      in_bcd = 16'h0001;
      for (int i = 0; i < 4; i++) tick;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp out_xs3", 32'(out_xs3), 32'h7654);
      stable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (!(out_valid && out_xs3 == 16'h7654 && !in_ready && busy)) stable = 1'b0;
      end
      chk("bp hold_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("bp done_exit busy", 32'(busy), 32'd0);
      chk("bp done_exit out_valid", 32'(out_valid), 32'd0);
      chk("bp done_exit in_ready", 32'(in_ready), 32'd1);
      tick;
      in_valid = 1'b0;
      chk("bp late_accept busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) tick;
      chk("bp second out_valid", 32'(out_valid), 32'd1);
      chk("bp second out_xs3", 32'(out_xs3), 32'h3334);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;

      // Flush on the second CONV cycle
      wait_ready("fl");
      in_valid = 1'b1;
      in_bcd   = 16'h5678;
      tick;
      in_valid = 1'b0;
      tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("fl busy", 32'(busy), 32'd0);
      chk("fl out_valid", 32'(out_valid), 32'd0);
      chk("fl out_err", 32'(out_err), 32'd0);
      chk("fl in_ready", 32'(in_ready), 32'd1);
      never_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (out_valid) never_valid = 1'b0;
      end
      chk("fl never_valid", 32'(never_valid), 32'd1);

      // Flush clears accumulated error bits
      in_valid = 1'b1;
      in_bcd   = 16'hFFFF;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      chk("fl2 partial_err", 32'(out_err), 32'b0011);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("fl2 err_cleared", 32'(out_err), 32'd0);
      chk("fl2 busy", 32'(busy), 32'd0);

      // Flush in IDLE blocks acceptance
      in_valid = 1'b1;
      in_bcd   = 16'h0001;
      flush    = 1'b1;
      tick;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_idle not_accepted", 32'(busy), 32'd0);
      run_word(16'h0001, 16'h3334, 4'b0000, "after_flush");

      // Asynchronous reset mid-CONV
      wait_ready("rst");
      in_valid = 1'b1;
      in_bcd   = 16'h1234;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      chk("mid partial_xs3", 32'(out_xs3), 32'h0067);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst out_xs3", 32'(out_xs3), 32'd0);
      chk("mid_rst busy", 32'(busy), 32'd0);
      chk("mid_rst in_ready", 32'(in_ready), 32'd0);
      tick;
      chk("mid_rst held in_ready", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("mid_rst release in_ready", 32'(in_ready), 32'd0);
      tick;
      chk("mid_rst edge in_ready", 32'(in_ready), 32'd1);

      // Back-to-back words with out_ready tied high
      exp_res[0] = 16'h3333;
      exp_res[1] = 16'hCCCC;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_bcd    = 16'h0000;
      nacc = 0;
      nres = 0;
      for (int c = 0; c < 40 && nres < 2; c++) begin
         acc = in_valid && in_ready;
         if (out_valid) begin
            chk($sformatf("b2b result%0d", nres), 32'(out_xs3), 32'(exp_res[nres]));
            nres++;
         end
         tick;
         if (acc && nacc < 2) begin
            acc_cyc[nacc] = c;
            nacc++;
            if (nacc == 1) in_bcd = 16'h9999;
            else in_valid = 1'b0;
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("b2b results_seen", 32'(nres), 32'd2);
      chk("b2b accepts_seen", 32'(nacc), 32'd2);
      if (nacc == 2)
         chk("b2b spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
Name: bcd_xs3_seq_ctrl

Overview:
- Sequencer that converts a packed multi-digit BCD word to packed Excess-3.
- Time-shares a single 4-bit combinational digit converter, one digit per clock, least-significant digit first.
- Also validates each digit.
- Sits between a BCD producer and a downstream consumer, with valid/ready handshakes on both sides.

Parameters:
- DIGITS, 4, number of BCD digits per word (>=1); data width is 4*DIGITS.
- IDXW, $clog2(DIGITS) with minimum 1, width of the digit index counter (derived; not overridden).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of any conversion in progress.
- in_valid  input  1  producer has a word on in_bcd.
- in_ready  output  1  block can accept a word.
- in_bcd  input  4*DIGITS  packed BCD; digit k is bits [4k+3:4k].
- out_valid  output  1  result word available.
- out_ready  input  1  consumer accepts the result.
- out_xs3  output  4*DIGITS  packed Excess-3 result.
- out_err  output  DIGITS  bit k set when input digit k was > 9.
- busy  output  1  high in CONV or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0.
  - Captured word, out_xs3 and out_err cleared to 0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first edge after release.
  - out_valid=0, busy=0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_bcd, clear out_xs3 and out_err, idx=0, go to CONV.
- CONV:
  - in_ready=0.
  - Each edge: digit d = captured[4*idx+3:4*idx] goes through the converter.
  - Result written to out_xs3 digit idx.
  - out_err[idx] = (d > 9).
  - idx increments.
  - When idx == DIGITS-1, go to DONE on the same edge.
- Converter arithmetic:
  - xs3 = (d + 3) mod 16, 4-bit wrap.
  - Invalid digits still produce (d+3) mod 16 (A->D, F->2); only the error bit flags them.
- DONE:
  - out_valid=1; out_xs3 and out_err held stable.
  - On out_ready: go to IDLE, out_valid drops on that edge.
  - The captured result stays on out_xs3 until the next accept.
- Latency:
  - Accept at edge T; digit conversions at edges T+1 .. T+DIGITS; out_valid high after edge T+DIGITS.
  - Minimum accept-to-accept spacing is DIGITS+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0 throughout.
- Simultaneous events:
  - In DONE with out_ready=1 and in_valid=1: the input is not accepted that cycle, because in_ready=0 in DONE.
  - It is accepted on the following IDLE cycle.
- flush:
  - In CONV or DONE: go to IDLE on the next edge; out_valid=0, idx=0, out_err cleared.
  - A partial result is never presented.
  - flush in IDLE blocks acceptance that cycle.
  - flush has priority over in_valid and out_ready.
- Reset mid-operation: immediate return to the reset values above; no output handshake completes.
- DIGITS=1: CONV lasts one cycle.
- idx never exceeds DIGITS-1; no wrap.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package bcd_pkg:
  - State enum (IDLE=2'd0, CONV=2'd1, DONE=2'd2).
  - Constant XS3_OFFSET=4'd3.
  - Constant BCD_MAX=4'd9.
- Sub-module bcd_xs3_digit: purely combinational.
  - Input: 4-bit d.
  - Outputs: 4-bit xs3 = d+3, 1-bit invalid = d>9.
  - Instantiated once and time-shared by the controller.

Test Plan:
- DIGITS=4, in_bcd=16'h1234 accepted at edge T -> out_valid rises after edge T+4; out_xs3=16'h4567, out_err=4'b0000; with out_ready=1, in_ready returns after one more edge.
- in_bcd=16'h9090 -> out_xs3=16'hC3C3, out_err=0; then 16'h0A0F -> out_xs3=16'h3D32, out_err=4'b0101.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> out_xs3 and out_valid stable, in_ready=0; in_valid held high is not accepted until DONE->IDLE.
- flush asserted on the 2nd CONV cycle of 16'h5678 -> IDLE next edge, out_valid never asserted, out_err=0; the next word 16'h0001 -> out_xs3=16'h3334.
- rst_n pulsed low mid-CONV (asynchronous, between edges) -> out_valid=0, out_xs3=0 and busy=0 immediately; in_ready low during reset, 1 after the first edge post-release.
- Back-to-back words 16'h0000 then 16'h9999 with out_ready tied high -> 16'h3333 then 16'hCCCC; accepts spaced exactly 6 cycles apart.
